// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_defs (package)
// Brief    : Shared SoC constants and the ROM loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package soc_defs;

    localparam int c_ROM_DEPTH_DEFAULT = 4096;
    localparam int c_ADDR_W_DEFAULT    = 12;
    localparam int c_INSTR_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/rom_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_byte_packer
// Brief    : Assembles four accepted bytes into a little-endian 32-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader_byte_packer
    import soc_defs::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [7:0]           i_byte,
    output logic [c_INSTR_W-1:0] o_word,
    output logic                 o_word_ready
);

    logic [1:0]           r_idx_q;
    logic [1:0]           w_idx_d;
    logic [c_INSTR_W-1:0] r_word_q;
    logic [c_INSTR_W-1:0] w_word_d;

    // Shifting in from the top leaves byte 0 in [7:0] after the fourth byte.
    always_comb begin
        w_idx_d  = r_idx_q;
        w_word_d = r_word_q;
        if (i_clear) begin
            w_idx_d  = 2'd0;
            w_word_d = '0;
        end else if (i_accept) begin
            w_idx_d  = r_idx_q + 2'd1;
            w_word_d = {i_byte, r_word_q[c_INSTR_W-1:8]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx_q  <= 2'd0;
            r_word_q <= '0;
        end else begin
            r_idx_q  <= w_idx_d;
            r_word_q <= w_word_d;
        end
    end

    assign o_word       = r_word_q;
    assign o_word_ready = i_accept && !i_clear && (r_idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Brief    : Byte-stream boot loader that fills the instruction ROM and holds
//            the core in reset until the requested word count has landed.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader
    import soc_defs::*;
#(
    parameter int ROM_DEPTH = c_ROM_DEPTH_DEFAULT,
    parameter int ADDR_W    = c_ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [ADDR_W:0]      load_words,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 rom_we,
    output logic [ADDR_W-1:0]    rom_waddr,
    output logic [c_INSTR_W-1:0] rom_wdata,
    output logic                 core_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [ADDR_W:0] c_ROM_DEPTH = (ADDR_W+1)'(ROM_DEPTH);
    localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);

    loader_state_e        r_state_q;
    loader_state_e        w_state_d;
    logic [ADDR_W:0]      r_load_words_q;
    logic [ADDR_W:0]      w_load_words_d;
    logic [ADDR_W:0]      r_word_cnt_q;
    logic [ADDR_W:0]      w_word_cnt_d;
    logic                 r_err_q;
    logic                 w_err_d;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_word_ready;
    logic [c_INSTR_W-1:0] w_word;
    logic [ADDR_W:0]      w_cnt_inc;

    assign w_accept  = byte_valid && (r_state_q == ST_RECV);
    assign w_start   = load_start && ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE));
    assign w_cnt_inc = r_word_cnt_q + c_ONE;

    rom_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_accept     (w_accept),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_load_words_d = r_load_words_q;
        w_word_cnt_d   = r_word_cnt_q;
        w_err_d        = r_err_q;
        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    w_load_words_d = load_words;
                    w_word_cnt_d   = '0;
                    w_err_d        = 1'b0;
                    if (load_words == '0) begin
                        w_state_d = ST_DONE;
                    end else if (load_words > c_ROM_DEPTH) begin
                        w_err_d   = 1'b1;
                        w_state_d = ST_IDLE;
                    end else begin
                        w_state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (w_word_ready) begin
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_word_cnt_d = w_cnt_inc;
                w_state_d    = (w_cnt_inc == r_load_words_q) ? ST_DONE : ST_RECV;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_load_words_q <= '0;
            r_word_cnt_q   <= '0;
            r_err_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_load_words_q <= w_load_words_d;
            r_word_cnt_q   <= w_word_cnt_d;
            r_err_q        <= w_err_d;
        end
    end

    // A reset landing on a WRITE cycle must not let the strobe reach the ROM.
    assign rom_we     = (r_state_q == ST_WRITE) && !rst;
    assign rom_waddr  = rom_we ? r_word_cnt_q[ADDR_W-1:0] : '0;
    assign rom_wdata  = rom_we ? w_word : '0;
    assign byte_ready = (r_state_q == ST_RECV);
    assign busy       = (r_state_q == ST_RECV) || (r_state_q == ST_WRITE);
    assign done       = (r_state_q == ST_DONE);
    assign core_hold  = (r_state_q != ST_DONE);
    assign err        = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Brief    : Directed self-checking bench for rom_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    localparam int ROM_DEPTH = 4096;
    localparam int ADDR_W    = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [ADDR_W:0]   load_words;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    int we_count = 0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    rom_loader #(.ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_words (load_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_valid && byte_ready) hs_count <= hs_count + 1;
        if (rom_we) begin
            we_count <= we_count + 1;
            wr_addr_q.push_back(rom_waddr);
            wr_data_q.push_back(rom_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic hold,
                              input logic bsy, input logic dn, input logic er);
        chk({tag, "/byte_ready"}, 64'(byte_ready), 64'(rdy));
        chk({tag, "/core_hold"},  64'(core_hold),  64'(hold));
        chk({tag, "/busy"},       64'(busy),       64'(bsy));
        chk({tag, "/done"},       64'(done),       64'(dn));
        chk({tag, "/err"},        64'(err),        64'(er));
    endtask

    task automatic chk_write(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        chk({tag, "/rom_we"},     64'(rom_we),     64'd1);
        chk({tag, "/byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "/rom_waddr"},  64'(rom_waddr),  64'(addr));
        chk({tag, "/rom_wdata"},  64'(rom_wdata),  64'(data));
    endtask

    task automatic start(input logic [ADDR_W:0] n);
        load_start = 1'b1;
        load_words = n;
        tick();
        load_start = 1'b0;
        load_words = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $error("FAIL byte_wait: observed=byte_ready stuck low expected=byte accepted");
        end else begin
            tick();
        end
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    initial begin
        int base_we;
        int base_hs;
        int gaps[3];
        logic [31:0] words[3];
        gaps  = '{1, 2, 0};
        words = '{32'h11223344, 32'hDEADBEEF, 32'h00A0B0C0};

        rst = 1'b1; load_start = 1'b0; load_words = '0;
        byte_valid = 1'b0; byte_data = 8'h00;
        tick(); tick();
        chk_status("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset/rom_we",    64'(rom_we),    64'd0);
        chk("reset/rom_waddr", 64'(rom_waddr), 64'd0);
        chk("reset/rom_wdata", 64'(rom_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // Basic single-word load
        start(13'd1);
        chk_status("w1_recv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'h00000013, 0);
        chk_write("w1", 12'd0, 32'h00000013);
        tick();
        chk_status("w1_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("w1/we_count", 64'(we_count), 64'd1);

        // Multi-word load with gaps between bytes
        base_we = we_count;
        base_hs = hs_count;
        start(13'd3);
        for (int k = 0; k < 3; k++) begin
            send_word(words[k], gaps[k]);
            chk_write($sformatf("w3_%0d", k), 12'(k), words[k]);
        end
        tick();
        chk_status("w3_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("w3/handshakes", 64'(hs_count - base_hs), 64'd12);
        chk("w3/we_count",   64'(we_count - base_we), 64'd3);

        // Zero-length load
        base_we = we_count;
        start(13'd0);
        chk_status("zero", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk("zero/we_count", 64'(we_count - base_we), 64'd0);

        // Overflow request
        base_hs = hs_count;
        start(13'd4097);
        chk_status("ovf", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        tick(); tick(); tick();
        byte_valid = 1'b0;
        chk("ovf/handshakes", 64'(hs_count - base_hs), 64'd0);
        chk("ovf/err_sticky", 64'(err), 64'd1);

        // load_start mid-session is ignored
        base_we = we_count;
        start(13'd2);
        chk_status("ign_recv", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'hA5A55A5A, 0);
        chk_write("ign0", 12'd0, 32'hA5A55A5A);
        tick();
        load_start = 1'b1;
        load_words = 13'd7;
        tick();
        load_start = 1'b0;
        load_words = '0;
        send_word(32'h01020304, 0);
        chk_write("ign1", 12'd1, 32'h01020304);
        tick();
        chk_status("ign_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ign/we_count", 64'(we_count - base_we), 64'd2);

        // Reload from DONE, then reset mid-word
        base_we = we_count;
        start(13'd2);
        chk_status("reload", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(32'hCAFEF00D, 0);
        chk_write("reload0", 12'd0, 32'hCAFEF00D);
        tick();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst/rom_we",    64'(rom_we),    64'd0);
        chk("midrst/rom_waddr", 64'(rom_waddr), 64'd0);
        chk("midrst/rom_wdata", 64'(rom_wdata), 64'd0);
        tick(); tick(); tick();
        chk("midrst/we_count", 64'(we_count - base_we), 64'd1);
        start(13'd1);
        send_word(32'h12345678, 0);
        chk_write("postrst", 12'd0, 32'h12345678);
        tick();
        chk_status("postrst_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full-depth load
        base_we = we_count;
        start(13'd4096);
        for (int i = 0; i < 4 * ROM_DEPTH; i++) send_byte(8'(i), 0);
        chk_write("full_last", 12'd4095, 32'hFFFEFDFC);
        tick();
        chk_status("full_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("full/we_count",   64'(we_count - base_we), 64'd4096);
        chk("full/first_addr", 64'(wr_addr_q[base_we]), 64'd0);
        chk("full/first_data", 64'(wr_data_q[base_we]), 64'h03020100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time program loader upstream of the SoC instruction ROM.
- Accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to consecutive ROM addresses starting at 0.
- Holds the core in reset until the programmed word count has landed. This replaces file-based ROM preload for silicon/FPGA bring-up.
- Sits between the host byte source (UART receiver or bench driver) and the ROM write port / core reset input.

Parameters:
- ROM_DEPTH, 4096, ROM depth in 32-bit words.
- ADDR_W, 12, ROM word-address width; must satisfy 2**ADDR_W >= ROM_DEPTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins a load session.
- load_words  input  ADDR_W+1  number of words to load; sampled on the load_start cycle.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_waddr  output  ADDR_W  ROM word address.
- rom_wdata  output  32  assembled instruction word.
- core_hold  output  1  1 = keep the core in reset.
- busy  output  1  session in progress.
- done  output  1  last session completed successfully; sticky until the next load_start or rst.
- err  output  1  load_words > ROM_DEPTH on the last start; sticky until the next load_start or rst.

Behaviour:
- Reset values:
  - State is IDLE.
  - byte_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0.
  - core_hold=1, busy=0, done=0, err=0.
  - Byte index and word counter are 0.
- Byte transfer occurs on a cycle with byte_valid && byte_ready. byte_valid without byte_ready is held off and no byte is consumed.
- States: IDLE, RECV, WRITE, DONE.
- IDLE, on load_start:
  - Capture load_words; clear done and err; set core_hold=1.
  - If load_words == 0, go to DONE.
  - Else if load_words > ROM_DEPTH, set err=1 and stay in IDLE with core_hold=1.
  - Else go to RECV with busy=1.
- RECV:
  - byte_ready=1.
  - Each accepted byte shifts into the word: byte 0 -> bits [7:0] … byte 3 -> bits [31:24].
  - The byte index wraps 3 -> 0.
  - On acceptance of byte 3, go to WRITE.
- WRITE (exactly one cycle):
  - rom_we=1, rom_wdata = assembled word, rom_waddr = word counter. byte_ready=0.
  - rom_we therefore asserts the cycle after the 4th byte is accepted.
  - Then increment the word counter. If the counter now equals load_words, go to DONE; else return to RECV.
- DONE:
  - busy=0, done=1, core_hold=0, byte_ready=0.
  - load_start re-enters the IDLE start logic. core_hold re-asserts on that same cycle's next edge.
- Sustained throughput: 4 bytes per 5 cycles.
- load_start while busy (RECV/WRITE) is ignored; load_words is not re-sampled.
- Bytes offered in IDLE/DONE/WRITE are not accepted (byte_ready=0).
- rst at any cycle, including mid-word or during WRITE:
  - Abort to reset values next edge; any partial word is discarded and no rom_we is issued.
  - ROM contents already written are untouched.
- rom_waddr never exceeds load_words-1 and never wraps within a session.
- Word counter and compare are ADDR_W+1 bits, so load_words == ROM_DEPTH is legal.

Decomposition:
- Shared package (soc_defs): ROM_DEPTH/ADDR_W defaults, 32-bit instruction width constant, loader state enum encoding (IDLE=0, RECV=1, WRITE=2, DONE=3).
- One natural sub-module: byte_packer (byte index counter + 32-bit shift assembly, with a word_ready output). FSM, counters and status live in rom_loader.

Test Plan:
- Basic 1-word load: load_words=1, bytes 13,00,00,00 back-to-back -> one rom_we, addr 0, data 0x00000013. rom_we is 1 cycle after the 4th byte. Then done=1, core_hold=0, busy=0.
- Multi-word with stalls: load_words=3, 12 bytes with random byte_valid gaps -> rom_we pulses at addr 0,1,2 with the correct little-endian words. byte_ready=0 during each WRITE cycle. Exactly 12 handshakes occur.
- Zero/overflow bounds:
  - load_words=0 -> DONE next cycle, no rom_we.
  - load_words=ROM_DEPTH+1 -> err=1, core_hold=1, no byte accepted.
  - load_words=ROM_DEPTH -> last write at addr ROM_DEPTH-1.
- Ignored start: load_start with load_words=7 pulsed mid-session of 2 -> session still ends after 2 words, done=1.
- Reset mid-word: after 2 bytes of word 1, assert rst 1 cycle -> all outputs at reset values. No rom_we for the partial word. A fresh load_words=1 session then writes addr 0 correctly.
- Reload: after DONE, load_start again -> core_hold=1 the next cycle and done cleared. Writes restart at addr 0.
